// File: rtl/axi_route_pkg.sv
// Shared types and constants for the W-channel router: route entry and interconnect map.
// Imported by the route FIFO and the router top.
package axi_route_pkg;

  typedef struct packed {
    logic [1:0] mst;
    logic [2:0] slv;
    logic [3:0] len;
  } route_t;

  localparam int         NUM_SLV  = 6;
  localparam logic [2:0] SLV_SINK = 3'd7;
  localparam logic [1:0] MST_CPU  = 2'd1;
  localparam logic [1:0] MST_DMA  = 2'd2;

endpackage

// File: rtl/axi_route_fifo.sv
// Synchronous FIFO of AW routes; push visible at head one cycle later.
// full/empty come from the registered count only, so a same-cycle pop never frees a slot for push.
module axi_route_fifo
  import axi_route_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   push,
  input  route_t din,
  input  logic   pop,
  output logic   full,
  output logic   empty,
  output route_t head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  route_t         r_mem [DEPTH];
  logic [AW-1:0]  r_wptr;
  logic [AW-1:0]  r_rptr;
  logic [AW:0]    r_cnt;
  logic           w_push;
  logic           w_pop;

  assign full   = (r_cnt == FULL_CNT);
  assign empty  = (r_cnt == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign head   = r_mem[r_rptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= din;
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      if (w_push && !w_pop) begin
        r_cnt <= r_cnt + (AW + 1)'(1);
      end else if (!w_push && w_pop) begin
        r_cnt <= r_cnt - (AW + 1)'(1);
      end
    end
  end

endmodule

// File: rtl/axi_wdata_router.sv
// Steers W beats of the granted master to the decoded slave (or an internal sink) per queued AW route.
// Zero-cycle data path; AW->W latency 1 cycle. AXI_WLAST_CHECK_EN: beat counter ends bursts and flags WLAST errors.
module axi_wdata_router
  import axi_route_pkg::*;
#(
  parameter int ROUTE_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               aw_push,
  input  logic [1:0]         aw_mst,
  input  logic [2:0]         aw_slv,
  input  logic [3:0]         aw_len,
  output logic               route_rdy,
  input  logic [31:0]        WDATA_M1,
  input  logic [3:0]         WSTRB_M1,
  input  logic               WLAST_M1,
  input  logic               WVALID_M1,
  output logic               WREADY_M1,
  input  logic [31:0]        WDATA_M2,
  input  logic [3:0]         WSTRB_M2,
  input  logic               WLAST_M2,
  input  logic               WVALID_M2,
  output logic               WREADY_M2,
  output logic [31:0]        WDATA_S,
  output logic [3:0]         WSTRB_S,
  output logic               WLAST_S,
  output logic [NUM_SLV-1:0] WVALID_S,
  input  logic [NUM_SLV-1:0] WREADY_S,
  output logic               werr
);

  route_t               w_head;
  route_t               w_din;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_sel1;
  logic                 w_sel2;
  logic [NUM_SLV-1:0]   w_oh;
  logic                 w_sink;
  logic                 w_rdy;
  logic [31:0]          w_mdat;
  logic [3:0]           w_mstrb;
  logic                 w_mlast;
  logic                 w_mvld;
  logic                 w_fire;
  logic                 w_last_s;
  logic                 w_chk_err;
  logic                 r_werr;

  // Illegal master codes never enter the queue.
  assign w_push = aw_push && ((aw_mst == MST_CPU) || (aw_mst == MST_DMA));
  assign w_din  = '{mst: aw_mst, slv: aw_slv, len: aw_len};

  axi_route_fifo #(
    .DEPTH (ROUTE_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .din   (w_din),
    .pop   (w_pop),
    .full  (w_full),
    .empty (w_empty),
    .head  (w_head)
  );

  assign w_sel1 = !w_empty && (w_head.mst == MST_CPU);
  assign w_sel2 = !w_empty && (w_head.mst == MST_DMA);

  always_comb begin
    w_oh = '0;
    for (int i = 0; i < NUM_SLV; i++) begin
      if (w_head.slv == 3'(i)) begin
        w_oh[i] = 1'b1;
      end
    end
  end

  // Any slave code outside the map (decode error included) drains into the sink.
  assign w_sink = (w_oh == '0);
  assign w_rdy  = w_sink ? 1'b1 : |(w_oh & WREADY_S);

  always_comb begin
    w_mdat  = '0;
    w_mstrb = '0;
    w_mlast = 1'b0;
    w_mvld  = 1'b0;
    if (w_sel1) begin
      w_mdat  = WDATA_M1;
      w_mstrb = WSTRB_M1;
      w_mlast = WLAST_M1;
      w_mvld  = WVALID_M1;
    end else if (w_sel2) begin
      w_mdat  = WDATA_M2;
      w_mstrb = WSTRB_M2;
      w_mlast = WLAST_M2;
      w_mvld  = WVALID_M2;
    end
  end

  assign w_fire = w_mvld && w_rdy;

`ifdef AXI_WLAST_CHECK_EN
  logic [3:0] r_beat;
  logic       w_end;

  assign w_end     = (r_beat == w_head.len);
  assign w_last_s  = (w_sel1 || w_sel2) && w_end;
  assign w_pop     = w_fire && w_end;
  assign w_chk_err = w_fire && (w_mlast != w_end);

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (w_pop) begin
      r_beat <= '0;
    end else if (w_fire) begin
      r_beat <= r_beat + 4'd1;
    end
  end
`else
  assign w_last_s  = w_mlast;
  assign w_pop     = w_fire && w_mlast;
  assign w_chk_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_werr <= 1'b0;
    end else if ((aw_push && w_full) || w_chk_err) begin
      r_werr <= 1'b1;
    end
  end

  assign route_rdy = !w_full;
  assign WREADY_M1 = w_sel1 && w_rdy;
  assign WREADY_M2 = w_sel2 && w_rdy;
  assign WDATA_S   = w_mdat;
  assign WSTRB_S   = w_mstrb;
  assign WLAST_S   = w_last_s;
  assign WVALID_S  = w_oh & {NUM_SLV{w_mvld}};
  assign werr      = r_werr;

endmodule

// File: tb/tb_axi_wdata_router.sv
// Directed bench for axi_wdata_router: single burst with backpressure, sink, WLAST check, queueing, reset.
// Inputs change on the falling edge; outputs are compared 1ns later.
module tb_axi_wdata_router;

  logic        clk;
  logic        rst;
  logic        aw_push;
  logic [1:0]  aw_mst;
  logic [2:0]  aw_slv;
  logic [3:0]  aw_len;
  logic        route_rdy;
  logic [31:0] WDATA_M1;
  logic [3:0]  WSTRB_M1;
  logic        WLAST_M1;
  logic        WVALID_M1;
  logic        WREADY_M1;
  logic [31:0] WDATA_M2;
  logic [3:0]  WSTRB_M2;
  logic        WLAST_M2;
  logic        WVALID_M2;
  logic        WREADY_M2;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic [5:0]  WVALID_S;
  logic [5:0]  WREADY_S;
  logic        werr;

  int n_chk;
  int n_pass;

  axi_wdata_router #(.ROUTE_DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .aw_push   (aw_push),
    .aw_mst    (aw_mst),
    .aw_slv    (aw_slv),
    .aw_len    (aw_len),
    .route_rdy (route_rdy),
    .WDATA_M1  (WDATA_M1),
    .WSTRB_M1  (WSTRB_M1),
    .WLAST_M1  (WLAST_M1),
    .WVALID_M1 (WVALID_M1),
    .WREADY_M1 (WREADY_M1),
    .WDATA_M2  (WDATA_M2),
    .WSTRB_M2  (WSTRB_M2),
    .WLAST_M2  (WLAST_M2),
    .WVALID_M2 (WVALID_M2),
    .WREADY_M2 (WREADY_M2),
    .WDATA_S   (WDATA_S),
    .WSTRB_S   (WSTRB_S),
    .WLAST_S   (WLAST_S),
    .WVALID_S  (WVALID_S),
    .WREADY_S  (WREADY_S),
    .werr      (werr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic route(input logic [1:0] m, input logic [2:0] s, input logic [3:0] l);
    aw_push = 1'b1;
    aw_mst  = m;
    aw_slv  = s;
    aw_len  = l;
  endtask

  initial begin
    n_chk = 0; n_pass = 0;
    rst = 1'b0; aw_push = 1'b0; aw_mst = '0; aw_slv = '0; aw_len = '0;
    WDATA_M1 = '0; WSTRB_M1 = '0; WLAST_M1 = 1'b0; WVALID_M1 = 1'b0;
    WDATA_M2 = '0; WSTRB_M2 = '0; WLAST_M2 = 1'b0; WVALID_M2 = 1'b0;
    WREADY_S = '0;

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_route_rdy", route_rdy, 1);
    chk("rst_wvalid_s", WVALID_S, 0);
    chk("rst_werr", werr, 0);
    chk("rst_wready_m1", WREADY_M1, 0);
    chk("rst_wlast_s", WLAST_S, 0);
    @(negedge clk);
    rst = 1'b1;

    // single burst M1->S2 len 3, with a 2-cycle slave stall, M2 noise ignored
    route(2'd1, 3'd2, 4'd3);
    WVALID_M1 = 1'b1; WDATA_M1 = 32'h11; WSTRB_M1 = 4'hF;
    #1;
    chk("early_stall_m1", WREADY_M1, 0);
    @(negedge clk);
    aw_push = 1'b0;
    WREADY_S = 6'b000100;
    WVALID_M2 = 1'b1; WDATA_M2 = 32'hDEAD_BEEF; WLAST_M2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      WDATA_M1 = 32'hA000_0000 + i;
      WLAST_M1 = (i == 3);
      if (i == 2) begin
        WREADY_S = 6'b000000;
        repeat (2) begin
          #1;
          chk("bp_wready_m1", WREADY_M1, 0);
          chk("bp_wvalid_s", WVALID_S, 6'b000100);
          chk("bp_wdata_s", WDATA_S, 32'hA000_0002);
          @(negedge clk);
        end
        WREADY_S = 6'b000100;
      end
      #1;
      chk("single_wvalid_s", WVALID_S, 6'b000100);
      chk("single_wready_m1", WREADY_M1, 1);
      chk("single_wready_m2", WREADY_M2, 0);
      chk("single_wdata_s", WDATA_S, 32'hA000_0000 + i);
      chk("single_wlast_s", WLAST_S, (i == 3) ? 1 : 0);
      chk("single_route_rdy", route_rdy, 1);
      @(negedge clk);
    end
    #1;
    chk("single_popped_rdy", WREADY_M1, 0);
    chk("single_popped_vld", WVALID_S, 0);
    chk("single_popped_route", route_rdy, 1);

    // sink burst M2 len 1
    WVALID_M1 = 1'b0; WLAST_M1 = 1'b0;
    route(2'd2, 3'd7, 4'd1);
    WREADY_S = 6'b111111; WVALID_M2 = 1'b1; WLAST_M2 = 1'b0;
    #1;
    chk("sink_early_m2", WREADY_M2, 0);
    @(negedge clk);
    aw_push = 1'b0;
    #1;
    chk("sink_wvalid_s0", WVALID_S, 0);
    chk("sink_wready_m2_0", WREADY_M2, 1);
    chk("sink_wready_m1", WREADY_M1, 0);
    @(negedge clk);
    WLAST_M2 = 1'b1;
    #1;
    chk("sink_wvalid_s1", WVALID_S, 0);
    chk("sink_wready_m2_1", WREADY_M2, 1);
    chk("sink_wlast_s", WLAST_S, 1);
    @(negedge clk);
    #1;
    chk("sink_popped", WREADY_M2, 0);
    chk("sink_werr", werr, 0);

    // early WLAST on a len-1 burst to S3
    WVALID_M2 = 1'b0; WLAST_M2 = 1'b0;
    route(2'd1, 3'd3, 4'd1);
    WVALID_M1 = 1'b1; WLAST_M1 = 1'b1; WDATA_M1 = 32'h3333; WREADY_S = 6'b001000;
    @(negedge clk);
    aw_push = 1'b0;
    #1;
    chk("lchk_wvalid_s", WVALID_S, 6'b001000);
`ifdef AXI_WLAST_CHECK_EN
    chk("lchk_wlast_s0", WLAST_S, 0);
    @(negedge clk);
    #1;
    chk("lchk_werr_set", werr, 1);
    chk("lchk_still_head", WREADY_M1, 1);
    WLAST_M1 = 1'b0;
    #1;
    chk("lchk_wlast_s1", WLAST_S, 1);
    @(negedge clk);
    #1;
    chk("lchk_popped", WREADY_M1, 0);
    chk("lchk_werr_sticky", werr, 1);
`else
    chk("lchk_wlast_s0", WLAST_S, 1);
    @(negedge clk);
    #1;
    chk("lchk_popped", WREADY_M1, 0);
    chk("lchk_werr", werr, 0);
`endif

    // queue: M2->S5 len0 then M1->S1 len1, plus a dropped push while full
    WLAST_M1 = 1'b0; WVALID_M1 = 1'b1; WDATA_M1 = 32'h5151;
    WREADY_S = 6'b100010;
    route(2'd2, 3'd5, 4'd0);
    @(negedge clk);
    route(2'd1, 3'd1, 4'd1);
    #1;
    chk("q_route_rdy1", route_rdy, 1);
    chk("q_wvalid_idle", WVALID_S, 0);
    chk("q_m1_stall0", WREADY_M1, 0);
    @(negedge clk);
    route(2'd1, 3'd0, 4'd0);
    #1;
    chk("q_full", route_rdy, 0);
    chk("q_m1_stall1", WREADY_M1, 0);
    @(negedge clk);
    aw_push = 1'b0;
    #1;
    chk("q_overflow_werr", werr, 1);
    chk("q_still_full", route_rdy, 0);
    WVALID_M2 = 1'b1; WLAST_M2 = 1'b1; WDATA_M2 = 32'h2525;
    #1;
    chk("q_m2_wvalid_s", WVALID_S, 6'b100000);
    chk("q_m2_wready", WREADY_M2, 1);
    chk("q_m2_wdata", WDATA_S, 32'h2525);
    chk("q_m1_stall2", WREADY_M1, 0);
    @(negedge clk);
    WVALID_M2 = 1'b0;
    #1;
    chk("q_m1_wvalid_s", WVALID_S, 6'b000010);
    chk("q_m1_wready", WREADY_M1, 1);
    chk("q_route_freed", route_rdy, 1);
    @(negedge clk);
    WLAST_M1 = 1'b1;
    #1;
    chk("q_m1_last", WLAST_S, 1);
    @(negedge clk);
    #1;
    chk("q_drop_absent_rdy", WREADY_M1, 0);
    chk("q_drop_absent_vld", WVALID_S, 0);

    // reset in the middle of a 4-beat burst to S4
    WLAST_M1 = 1'b0;
    route(2'd1, 3'd4, 4'd3);
    WREADY_S = 6'b010000;
    @(negedge clk);
    aw_push = 1'b0;
    #1;
    chk("mr_wvalid_s", WVALID_S, 6'b010000);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mr_route_rdy", route_rdy, 1);
    chk("mr_wvalid_s0", WVALID_S, 0);
    chk("mr_werr", werr, 0);
    chk("mr_wready_m1", WREADY_M1, 0);
    @(negedge clk);
    #1;
    chk("mr_no_fwd_rdy", WREADY_M1, 0);
    chk("mr_no_fwd_vld", WVALID_S, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
